// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures a PWM line's period/high time and reports duty in percent (PWM_DUTY_AVG_EN: 4-result average).
// duty_valid lands CNT_W+8 clks after the period-ending edge; no backpressure, periods ending on a busy divider raise overrun.
module pwm_duty_meter #(
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 8000000,
  parameter int MIN_PERIOD     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [6:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic             duty_valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             overrun,
  output logic             glitch
);

  localparam int NW = CNT_W + 7;
  localparam int IW = $clog2(NW + 1);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [NW-1:0]    PCT      = NW'(100);
  localparam logic [IW-1:0]    ITER_END = IW'(NW);
  localparam logic [IW-1:0]    ITER_ONE = IW'(1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, r, f;
  logic [CNT_W-1:0]       cnt, cnt_n, hcnt, hcnt_n;
  logic                   period_end, to_high, to_low;

  logic                   div_busy, div_done, div_ge;
  logic [IW-1:0]          div_iter;
  logic [CNT_W-1:0]       div_rem, div_rem_n, div_dvsr;
  logic [NW-1:0]          div_quo;
  logic [CNT_W:0]         div_trial;
  logic [6:0]             duty_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
  assign r = s & ~s_d;
  assign f = ~s & s_d;

  // Edges take priority over the timeout; enable=0 overrides everything.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    hcnt_n     = hcnt;
    period_end = 1'b0;
    to_high    = 1'b0;
    to_low     = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && r) begin
          state_n = S_HIGH;
          cnt_n   = CNT_ONE;
          hcnt_n  = '0;
        end
      end
      S_HIGH: begin
        if (!enable) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          hcnt_n  = '0;
        end else if (f) begin
          state_n = S_LOW;
          hcnt_n  = cnt;
          cnt_n   = cnt + CNT_ONE;
        end else if (cnt >= TO_LIM) begin
          to_high = 1'b1;
          state_n = S_IDLE;
          cnt_n   = '0;
          hcnt_n  = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_LOW: begin
        if (!enable) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          hcnt_n  = '0;
        end else if (r) begin
          period_end = 1'b1;
          state_n    = S_HIGH;
          cnt_n      = CNT_ONE;
          hcnt_n     = '0;
        end else if (cnt >= TO_LIM) begin
          to_low  = 1'b1;
          state_n = S_IDLE;
          cnt_n   = '0;
          hcnt_n  = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        hcnt_n  = '0;
      end
    endcase
  end

  // Restoring divide step: remainder stays below the divisor, so CNT_W bits hold it.
  always_comb begin
    div_trial = {div_rem, div_quo[NW-1]};
    div_ge    = div_trial >= {1'b0, div_dvsr};
    div_rem_n = div_ge ? CNT_W'(div_trial - {1'b0, div_dvsr}) : div_trial[CNT_W-1:0];
  end

  assign div_done = div_busy && (div_iter == ITER_END);

`ifdef PWM_DUTY_AVG_EN
  logic [6:0] hist0, hist1, hist2;
  logic [1:0] hist_cnt;
  logic [8:0] avg_sum;

  // hist_cnt counts earlier results; three of them means a full window of four.
  always_comb begin
    avg_sum  = {2'b00, div_quo[6:0]};
    duty_res = div_quo[6:0];
    case (hist_cnt)
      2'd0: duty_res = div_quo[6:0];
      2'd1, 2'd2: begin
        avg_sum  = {2'b00, div_quo[6:0]} + {2'b00, hist0};
        duty_res = 7'(avg_sum >> 1);
      end
      default: begin
        avg_sum  = {2'b00, div_quo[6:0]} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
        duty_res = 7'(avg_sum >> 2);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist0    <= '0;
      hist1    <= '0;
      hist2    <= '0;
      hist_cnt <= '0;
    end else if (to_high || to_low) begin
      hist_cnt <= '0;
    end else if (div_done) begin
      hist0 <= div_quo[6:0];
      hist1 <= hist0;
      hist2 <= hist1;
      if (hist_cnt != 2'd3) hist_cnt <= hist_cnt + 2'd1;
    end
  end
`else
  assign duty_res = div_quo[6:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      duty       <= '0;
      period     <= '0;
      duty_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
      overrun    <= 1'b0;
      glitch     <= 1'b0;
      div_busy   <= 1'b0;
      div_iter   <= '0;
      div_rem    <= '0;
      div_quo    <= '0;
      div_dvsr   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hcnt       <= hcnt_n;
      duty_valid <= 1'b0;
      glitch     <= 1'b0;

      if (div_busy) begin
        if (div_done) begin
          div_busy   <= 1'b0;
          duty       <= duty_res;
          duty_valid <= 1'b1;
          stuck_high <= 1'b0;
          stuck_low  <= 1'b0;
        end else begin
          div_rem  <= div_rem_n;
          div_quo  <= {div_quo[NW-2:0], div_ge};
          div_iter <= div_iter + ITER_ONE;
        end
      end

      if (period_end) begin
        if (cnt < MIN_P) begin
          glitch <= 1'b1;
        end else if (!div_busy) begin
          div_busy <= 1'b1;
          div_iter <= '0;
          div_rem  <= '0;
          div_quo  <= NW'(hcnt) * PCT;
          div_dvsr <= cnt;
          period   <= cnt;
        end else begin
          overrun <= 1'b1;
        end
      end

      // A timeout lands after any divider write in the same cycle, so its value wins.
      if (to_high) begin
        duty       <= 7'd100;
        stuck_high <= 1'b1;
        duty_valid <= 1'b1;
      end
      if (to_low) begin
        duty       <= 7'd0;
        stuck_low  <= 1'b1;
        duty_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: CNT_W=24, TIMEOUT_CYCLES=1000, MIN_PERIOD=4, SYNC_STAGES=2.
module tb_pwm_duty_meter;

  localparam int CNT_W = 24;
  // 2 sync flops + edge-detect flop + CNT_W+8 divider cycles, counted from the pwm_in drive.
  localparam int LAT = 3 + CNT_W + 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic             enable;
  logic [6:0]       duty;
  logic [CNT_W-1:0] period;
  logic             duty_valid;
  logic             stuck_high;
  logic             stuck_low;
  logic             overrun;
  logic             glitch;

  pwm_duty_meter #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(1000),
    .MIN_PERIOD(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .enable(enable),
    .duty(duty),
    .period(period),
    .duty_valid(duty_valid),
    .stuck_high(stuck_high),
    .stuck_low(stuck_low),
    .overrun(overrun),
    .glitch(glitch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   last_rise_cyc = 0;
  int   glitch_cnt = 0;
  int   dv_consec = 0;
  logic dv_prev = 1'b0;
  int   dv_duty[$];
  int   dv_period[$];
  int   dv_lat[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (duty_valid === 1'b1) begin
        dv_duty.push_back(int'(duty));
        dv_period.push_back(int'(period));
        dv_lat.push_back(cyc - last_rise_cyc);
        if (dv_prev) dv_consec++;
      end
      if (glitch === 1'b1) glitch_cnt++;
    end
    dv_prev = (duty_valid === 1'b1);
  end

  task automatic hold(input logic v, input int n);
    if (v && !pwm_in) last_rise_cyc = cyc;
    pwm_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    dv_duty.delete();
    dv_period.delete();
    dv_lat.delete();
    glitch_cnt = 0;
  endtask

  task automatic park();
    enable = 1'b0;
    hold(1'b0, 3);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (duty !== 7'd0) begin tests_failed++; $display("FAIL reset_duty: got %0d want 0", duty); end
    tests_run++; if (period !== '0) begin tests_failed++; $display("FAIL reset_period: got %0d want 0", period); end
    tests_run++; if (duty_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_duty_valid: got %b want 0", duty_valid); end
    tests_run++; if (stuck_high !== 1'b0) begin tests_failed++; $display("FAIL reset_stuck_high: got %b want 0", stuck_high); end
    tests_run++; if (stuck_low !== 1'b0) begin tests_failed++; $display("FAIL reset_stuck_low: got %b want 0", stuck_low); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests_run++; if (glitch !== 1'b0) begin tests_failed++; $display("FAIL reset_glitch: got %b want 0", glitch); end
    rst_n = 1'b1; enable = 1'b1;
    hold(1'b0, 5);
  endtask

  task automatic test_steady();
    clear_log();
    for (int p = 0; p < 5; p++) begin
      hold(1'b1, 40);
      hold(1'b0, 60);
    end
    tests_run++; if (dv_duty.size() != 4) begin tests_failed++; $display("FAIL steady_count: got %0d want 4", dv_duty.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= dv_duty.size() || dv_duty[i] != 40 || dv_period[i] != 100) begin
        tests_failed++;
        $display("FAIL steady_result[%0d]: got duty %0d period %0d want 40/100", i,
                 (i < dv_duty.size()) ? dv_duty[i] : -1, (i < dv_period.size()) ? dv_period[i] : -1);
      end
      tests_run++;
      if (i >= dv_lat.size() || dv_lat[i] != LAT) begin
        tests_failed++;
        $display("FAIL steady_latency[%0d]: got %0d want %0d", i, (i < dv_lat.size()) ? dv_lat[i] : -1, LAT);
      end
    end
    park();
  endtask

  task automatic test_extremes();
    clear_log();
    hold(1'b1, 1);  hold(1'b0, 99);
    hold(1'b1, 99); hold(1'b0, 1);
    hold(1'b1, 40); hold(1'b0, 60);
    tests_run++; if (dv_duty.size() != 2) begin tests_failed++; $display("FAIL extremes_count: got %0d want 2", dv_duty.size()); end
    tests_run++;
    if (dv_duty.size() < 1 || dv_duty[0] != 1 || dv_period[0] != 100) begin
      tests_failed++; $display("FAIL extremes_low_duty: got %0d want 1 (period 100)", (dv_duty.size() > 0) ? dv_duty[0] : -1);
    end
    tests_run++;
    if (dv_duty.size() < 2 || dv_duty[1] != 99 || dv_period[1] != 100) begin
      tests_failed++; $display("FAIL extremes_high_duty: got %0d want 99 (period 100)", (dv_duty.size() > 1) ? dv_duty[1] : -1);
    end
    tests_run++; if (glitch_cnt != 0) begin tests_failed++; $display("FAIL extremes_glitch: got %0d want 0", glitch_cnt); end
    park();
  endtask

  task automatic test_glitch();
    clear_log();
    for (int p = 0; p < 6; p++) begin
      hold(1'b1, 1);
      hold(1'b0, 2);
    end
    hold(1'b0, 5);
    tests_run++; if (glitch_cnt != 5) begin tests_failed++; $display("FAIL glitch_count: got %0d want 5", glitch_cnt); end
    tests_run++; if (dv_duty.size() != 0) begin tests_failed++; $display("FAIL glitch_no_valid: got %0d pulses want 0", dv_duty.size()); end
    tests_run++; if (duty !== 7'd99) begin tests_failed++; $display("FAIL glitch_duty_held: got %0d want 99", duty); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL glitch_overrun: got %b want 0", overrun); end
    park();
  endtask

  task automatic test_stuck();
    clear_log();
    hold(1'b1, 40); hold(1'b0, 60);
    hold(1'b1, 1200);
    tests_run++; if (stuck_high !== 1'b1) begin tests_failed++; $display("FAIL stuck_high_set: got %b want 1", stuck_high); end
    tests_run++; if (duty !== 7'd100) begin tests_failed++; $display("FAIL stuck_high_duty: got %0d want 100", duty); end
    tests_run++;
    if (dv_duty.size() != 2 || dv_duty[1] != 100) begin
      tests_failed++; $display("FAIL stuck_high_pulses: got %0d pulses want 2 (40 then 100)", dv_duty.size());
    end
    hold(1'b0, 40); hold(1'b1, 40); hold(1'b0, 40);
    hold(1'b1, 40); hold(1'b0, 40);
    tests_run++; if (duty !== 7'd50) begin tests_failed++; $display("FAIL resume_duty: got %0d want 50", duty); end
    tests_run++; if (period !== 24'd80) begin tests_failed++; $display("FAIL resume_period: got %0d want 80", period); end
    tests_run++; if (stuck_high !== 1'b0) begin tests_failed++; $display("FAIL resume_stuck_high: got %b want 0", stuck_high); end
    hold(1'b0, 1000);
    tests_run++; if (stuck_low !== 1'b1) begin tests_failed++; $display("FAIL stuck_low_set: got %b want 1", stuck_low); end
    tests_run++; if (duty !== 7'd0) begin tests_failed++; $display("FAIL stuck_low_duty: got %0d want 0", duty); end
    tests_run++; if (period !== 24'd80) begin tests_failed++; $display("FAIL stuck_low_period: got %0d want 80", period); end
    tests_run++; if (dv_duty.size() != 4) begin tests_failed++; $display("FAIL stuck_pulse_count: got %0d want 4", dv_duty.size()); end
    park();
  endtask

  task automatic test_overrun();
    clear_log();
    for (int p = 0; p < 8; p++) begin
      hold(1'b1, 5);
      hold(1'b0, 15);
    end
    hold(1'b0, 30);
    tests_run++; if (dv_duty.size() != 4) begin tests_failed++; $display("FAIL overrun_count: got %0d want 4", dv_duty.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= dv_duty.size() || dv_duty[i] != 25 || dv_period[i] != 20) begin
        tests_failed++;
        $display("FAIL overrun_result[%0d]: got duty %0d want 25 (period 20)", i, (i < dv_duty.size()) ? dv_duty[i] : -1);
      end
    end
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    tests_run++; if (stuck_low !== 1'b0) begin tests_failed++; $display("FAIL overrun_stuck_low_clear: got %b want 0", stuck_low); end
    tests_run++; if (dv_consec != 0) begin tests_failed++; $display("FAIL back_to_back_valid: got %0d want 0", dv_consec); end
    park();
  endtask

  task automatic test_reset_mid_div();
    clear_log();
    hold(1'b1, 40); hold(1'b0, 60);
    hold(1'b1, 10);
    rst_n = 1'b0;
    hold(1'b0, 2);
    rst_n = 1'b1;
    hold(1'b0, 50);
    tests_run++; if (dv_duty.size() != 0) begin tests_failed++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", dv_duty.size()); end
    tests_run++; if (duty !== 7'd0) begin tests_failed++; $display("FAIL rst_mid_duty: got %0d want 0", duty); end
    tests_run++; if (period !== '0) begin tests_failed++; $display("FAIL rst_mid_period: got %0d want 0", period); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_enable_abort();
    clear_log();
    hold(1'b1, 40); hold(1'b0, 30);
    enable = 1'b0;
    hold(1'b0, 2);
    enable = 1'b1;
    hold(1'b0, 28);
    hold(1'b1, 30); hold(1'b0, 70);
    hold(1'b1, 30); hold(1'b0, 70);
    tests_run++; if (dv_duty.size() != 1) begin tests_failed++; $display("FAIL abort_count: got %0d want 1", dv_duty.size()); end
    tests_run++;
    if (dv_duty.size() < 1 || dv_duty[0] != 30 || dv_period[0] != 100) begin
      tests_failed++; $display("FAIL abort_result: got %0d want 30 (period 100)", (dv_duty.size() > 0) ? dv_duty[0] : -1);
    end
    tests_run++; if (duty !== 7'd30) begin tests_failed++; $display("FAIL abort_duty: got %0d want 30", duty); end
    park();
  endtask

  initial begin
    test_reset();
    test_steady();
    test_extremes();
    test_glitch();
    test_stuck();
    test_overrun();
    test_reset_mid_div();
    test_enable_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Receive-side counterpart of the motor PWM generator: samples a PWM waveform, measures period and high time, and reports the duty as an integer percent 0..100.
- Sits on the feedback path from the motor drive outputs (pwm1/pwm2 taps) to the controller/debug logic.
- Lets the closed loop check that the commanded speed actually reached the drive, and detects a stalled (stuck) PWM line.

Parameters:
- CNT_W, 24, width of period/high counters and of the period output.
- TIMEOUT_CYCLES, 8000000, clocks without an edge before a stuck-line result; must be < 2^CNT_W.
- MIN_PERIOD, 4, periods shorter than this are rejected as glitches.
- SYNC_STAGES, 2, input synchronizer depth (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pwm_in  in  1  asynchronous PWM waveform to measure
- enable  in  1  1 = measure; 0 = abort the current measurement and return to IDLE
- duty  out  7  last duty result in percent, 0..100
- period  out  CNT_W  last accepted period in clocks
- duty_valid  out  1  one-cycle pulse when duty/period update
- stuck_high  out  1  sticky; set by high timeout, cleared by the next accepted period
- stuck_low  out  1  sticky; set by low timeout, cleared by the next accepted period
- overrun  out  1  sticky; a period completed while the divider was busy; cleared only by reset
- glitch  out  1  one-cycle pulse when a period < MIN_PERIOD is rejected

Behaviour:
- Reset values (rst_n=0 at a clk edge): duty=0, period=0, all flags 0, FSM=IDLE, divider idle, synchronizer cleared to 0.
- Synchronizer: pwm_in passes through SYNC_STAGES flops to give s. An edge detector compares s with its previous value. Rising edge = r, falling edge = f.
- Measure FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for r with enable=1. On r: cnt<=1, hcnt<=0, go to HIGH. The first rising edge never produces a result.
  - HIGH: cnt increments each clock. On f: hcnt<=cnt, go to LOW.
  - LOW: cnt increments each clock. On r, a period ends: P = cnt, H = hcnt.
    - If P < MIN_PERIOD: pulse glitch, discard.
    - Else, if the divider is idle: load it, period<=P.
    - Else (divider busy): set overrun, discard.
    - In all three cases restart with cnt<=1, hcnt<=0, go to HIGH.
  - Example: 40 clocks high / 60 low gives P=100, H=40.
- Timeout:
  - In HIGH, cnt reaching TIMEOUT_CYCLES without f: duty<=100, stuck_high<=1, duty_valid pulse, go to IDLE.
  - In LOW, same without r: duty<=0, stuck_low<=1, duty_valid pulse, go to IDLE.
  - If the timeout and an edge fall in the same cycle, the edge wins.
- enable=0: FSM goes to IDLE next cycle and counters clear. Outputs and flags hold. A divider already running completes and reports.
- Divider:
  - Unsigned restoring divide of N = H*100 (CNT_W+7 bits) by P, one quotient bit per clock, CNT_W+7 iterations.
  - Quotient is <= 100 since H < P. Write the low 7 bits to duty.
- Latency: duty_valid pulses exactly CNT_W+8 clocks after the clock in which the measure FSM samples the period-ending r (1 load cycle, CNT_W+7 iterations).
  - The same cycle updates duty, and clears stuck_high/stuck_low.
  - period updates at load time.
- Simultaneous events:
  - A divider completion and a timeout in the same cycle: the divider result is written first, then the timeout value overrides duty. Both flag effects apply; a single duty_valid pulse.
  - Reset mid-division aborts with no duty_valid.
- duty_valid is never asserted two cycles in a row.

Optional Feature:
- PWM_DUTY_AVG_EN defined:
  - duty reports the average of the last 4 divider results: 9-bit sum, >>2, truncated.
  - Until 4 results exist, the average is over the results available so far (1, 2 or 4 divisor via shift; 3 uses the 2 newest).
  - A timeout clears the history and forces 0/100 directly.
  - Latency is unchanged; the add/shift is in the final divider cycle.
- Undefined: duty is the latest single result; no history registers.

Test Plan:
- CNT_W=24, TIMEOUT_CYCLES=1000; steady PWM of 40 high / 60 low for 5 periods.
  - Required: first period reports nothing, then 4 duty_valid pulses with duty=40, period=100.
  - Each pulse exactly CNT_W+8 clocks after the sampled r.
- PWM of 1 high / 99 low, then 99 high / 1 low.
  - Required: duty=1 then duty=99, period=100; no glitch.
- Hold pwm_in=1 for 1200 clocks after a normal period.
  - Required: stuck_high=1, duty=100, one duty_valid.
  - Resume 50/50 with period 80: after the second r, duty=50, period=80, stuck_high cleared.
- Pulse train with period 3 (MIN_PERIOD=4).
  - Required: glitch pulses once per period, no duty_valid, duty unchanged.
- Period 20 with CNT_W=24.
  - Required: periods ending while the divider is busy set overrun and are discarded; completed results are still correct.
- Assert rst_n=0 mid-division, then enable=0 mid-period.
  - Required: reset gives all outputs 0 and no pulse.
  - enable=0 gives return to IDLE with the first subsequent period unreported.
